ccd_exposure_ctrl: RTL

Sequences one complete CCD frame through the existing ccd_readout block. The order is: N clean (flush) passes, then a timed exposure with the shutter open, then one readout pass in 1x1 or 2x2 mode. It drives the readout block's toggle/mode inputs and monitors its busy output. It sits between the host command/register logic and ccd_readout, and provides start/abort, done and error status.

---
 rtl/ccd_exposure_ctrl_pkg.sv | 33 +++
 rtl/ccd_exposure_timer.sv | 48 ++++
 rtl/ccd_exposure_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ccd_exposure_ctrl_pkg.sv
// Shared definitions for the CCD exposure controller: readout mode codes,
// status phase encoding and the controller state type.
package ccd_exposure_ctrl_pkg;

  localparam logic [1:0] ccd_mode_clean       = 2'd0;
  localparam logic [1:0] ccd_mode_readout_1x1 = 2'd1;
  localparam logic [1:0] ccd_mode_readout_2x2 = 2'd2;

  localparam logic [2:0] ccd_phase_idle    = 3'd0;
  localparam logic [2:0] ccd_phase_cln_tog = 3'd1;
  localparam logic [2:0] ccd_phase_cln_run = 3'd2;
  localparam logic [2:0] ccd_phase_expose  = 3'd3;
  localparam logic [2:0] ccd_phase_rd_tog  = 3'd4;
  localparam logic [2:0] ccd_phase_rd_run  = 3'd5;
  localparam logic [2:0] ccd_phase_finish  = 3'd6;

  // State codes double as the phase readback value.
  typedef enum logic [2:0] {
    IDLE    = ccd_phase_idle,
    CLN_TOG = ccd_phase_cln_tog,
    CLN_RUN = ccd_phase_cln_run,
    EXPOSE  = ccd_phase_expose,
    RD_TOG  = ccd_phase_rd_tog,
    RD_RUN  = ccd_phase_rd_run,
    FINISH  = ccd_phase_finish
  } state_t;

  function automatic logic mode_valid(input logic [1:0] m);
    return (m == ccd_mode_readout_1x1) ||
           (m == ccd_mode_readout_2x2);
  endfunction

endpackage

// File: rtl/ccd_exposure_timer.sv
// Exposure timer: TICK_DIV-cycle prescaler feeding an EXP_W-bit tick counter.
// expired is high on the last counted cycle of target*TICK_DIV.
module ccd_exposure_timer
  import ccd_exposure_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int EXP_W    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             count,
  input  logic [EXP_W-1:0] target,
  output logic             expired
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]    pre_q;
  logic [EXP_W-1:0] tick_q;
  logic [EXP_W-1:0] last_tick;
  logic             wrap;

  assign wrap      = (pre_q == PRE_MAX);
  assign last_tick = target - EXP_W'(1);
  assign expired   = count && wrap && (tick_q == last_tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= '0;
    end else if (load) begin
      pre_q  <= '0;
      tick_q <= '0;
    end else if (count) begin
      if (wrap) begin
        pre_q <= '0;
        // Saturate so a full-scale target never wraps back to zero.
        if (tick_q != '1)
          tick_q <= tick_q + EXP_W'(1);
      end else begin
        pre_q <= pre_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ccd_exposure_ctrl.sv
// Frame sequencer for ccd_readout: clean passes, timed shutter-open exposure,
// then one readout pass, with abort, busy watchdog and status outputs.
module ccd_exposure_ctrl
  import ccd_exposure_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int EXP_W        = 24,
  parameter int CLEAN_W      = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [EXP_W-1:0]   cfg_exp,
  input  logic [CLEAN_W-1:0] cfg_clean_n,
  input  logic [1:0]         cfg_mode,
  output logic [1:0]         ccd_mode,
  output logic               ccd_toggle,
  input  logic               ccd_busy,
  output logic               shutter,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               error,
  output logic [2:0]         phase
);

  localparam int WD_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(BUSY_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [CLEAN_W-1:0] clean_q, clean_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [1:0]         rmode_q, rmode_d;
  logic               pend_q, pend_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [1:0]         mode_q, mode_d;
  logic               tog_q, tog_d;
  logic               shut_q, shut_d;
  logic               done_q, done_d;
  logic               abt_q, abt_d;
  logic               err_q, err_d;
  logic               busy_q;

  logic go_clean, go_expose, go_read;
  logic tmr_load, tmr_count, tmr_expired;

  ccd_exposure_timer #(
    .TICK_DIV (TICK_DIV),
    .EXP_W    (EXP_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .count   (tmr_count),
    .target  (exp_q),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    clean_d   = clean_q;
    exp_d     = exp_q;
    rmode_d   = rmode_q;
    pend_d    = pend_q;
    wd_d      = wd_q;
    mode_d    = mode_q;
    tog_d     = tog_q;
    shut_d    = shut_q;
    err_d     = err_q;
    done_d    = 1'b0;
    abt_d     = 1'b0;
    go_clean  = 1'b0;
    go_expose = 1'b0;
    go_read   = 1'b0;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          clean_d = cfg_clean_n;
          exp_d   = cfg_exp;
          rmode_d = cfg_mode;
          pend_d  = 1'b0;
          if (!mode_valid(cfg_mode)) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
            if (cfg_clean_n != '0)  go_clean  = 1'b1;
            else if (cfg_exp != '0) go_expose = 1'b1;
            else                    go_read   = 1'b1;
          end
        end
      end

      CLN_TOG, RD_TOG: begin
        if (abort) pend_d = 1'b1;
        // Toggle is held only until busy is seen, so it is low again
        // long before ccd_readout drops busy and rearms.
        if (ccd_busy) begin
          tog_d   = 1'b0;
          state_d = (state_q == CLN_TOG) ? CLN_RUN : RD_RUN;
        end else if (wd_q == WD_LAST) begin
          tog_d   = 1'b0;
          err_d   = 1'b1;
          pend_d  = 1'b0;
          mode_d  = ccd_mode_clean;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      CLN_RUN: begin
        if (abort) pend_d = 1'b1;
        if (!ccd_busy) begin
          if (pend_d) begin
            abt_d   = 1'b1;
            pend_d  = 1'b0;
            mode_d  = ccd_mode_clean;
            state_d = IDLE;
          end else begin
            clean_d = clean_q - CLEAN_W'(1);
            if (clean_d != '0)    go_clean  = 1'b1;
            else if (exp_q != '0) go_expose = 1'b1;
            else                  go_read   = 1'b1;
          end
        end
      end

      EXPOSE: begin
        tmr_count = 1'b1;
        if (abort) begin
          shut_d  = 1'b0;
          abt_d   = 1'b1;
          state_d = IDLE;
        end else if (tmr_expired) begin
          shut_d  = 1'b0;
          go_read = 1'b1;
        end
      end

      RD_RUN: begin
        if (abort) pend_d = 1'b1;
        if (!ccd_busy) begin
          mode_d = ccd_mode_clean;
          if (pend_d) begin
            abt_d   = 1'b1;
            pend_d  = 1'b0;
            state_d = IDLE;
          end else begin
            done_d  = 1'b1;
            state_d = FINISH;
          end
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    if (go_clean) begin
      state_d = CLN_TOG;
      mode_d  = ccd_mode_clean;
      tog_d   = 1'b1;
      wd_d    = '0;
    end
    if (go_expose) begin
      state_d  = EXPOSE;
      mode_d   = ccd_mode_clean;
      shut_d   = 1'b1;
      tmr_load = 1'b1;
    end
    if (go_read) begin
      state_d = RD_TOG;
      mode_d  = rmode_d;
      tog_d   = 1'b1;
      wd_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      clean_q <= '0;
      exp_q   <= '0;
      rmode_q <= ccd_mode_clean;
      pend_q  <= 1'b0;
      wd_q    <= '0;
      mode_q  <= ccd_mode_clean;
      tog_q   <= 1'b0;
      shut_q  <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clean_q <= clean_d;
      exp_q   <= exp_d;
      rmode_q <= rmode_d;
      pend_q  <= pend_d;
      wd_q    <= wd_d;
      mode_q  <= mode_d;
      tog_q   <= tog_d;
      shut_q  <= shut_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign ccd_mode   = mode_q;
  assign ccd_toggle = tog_q;
  assign shutter    = shut_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = abt_q;
  assign error      = err_q;
  assign phase      = state_q;

endmodule
